// File: rtl/sdi_clk_pkg.sv
// Shared types and constants for the SDI clock-rate monitor.
// Holds the MODE codes, the rate classes, the lock FSM states and the
// rate-to-MODE mapping used when a lock is declared.
`timescale 1ns/1ps
package sdi_clk_pkg;

    localparam logic [2:0] MODE_HD    = 3'b000;
    localparam logic [2:0] MODE_SD    = 3'b001;
    localparam logic [2:0] MODE_3G    = 3'b010;
    localparam logic [2:0] MODE_6G    = 3'b100;
    localparam logic [2:0] MODE_12G   = 3'b101;
    localparam logic [2:0] MODE_12G_1 = 3'b110;

    typedef enum logic [1:0] {
        R_UNKNOWN,
        R74,
        R148,
        R297
    } rate_e;

    typedef enum logic [1:0] {
        HUNT,
        CHECK,
        LOCKED
    } state_e;

    // Only the three measurable rates have a MODE; anything else falls back to HD.
    function automatic logic [2:0] rate_to_mode(input rate_e r);
        logic [2:0] m;
        m = MODE_HD;
        case (r)
            R74:     m = MODE_HD;
            R148:    m = MODE_3G;
            R297:    m = MODE_12G;
            default: m = MODE_HD;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/sdi_sync_edge.sv
// Two-flop synchroniser for an asynchronous toggle, followed by a delay flop
// so that either polarity of transition produces a one-cycle edge_pulse.
`timescale 1ns/1ps
module sdi_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic sig_async,
    output logic edge_pulse
);

    logic sync1_q;
    logic sync2_q;
    logic dly_q;

    // Metastability chain plus one extra stage for edge comparison.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            dly_q   <= 1'b0;
        end else begin
            sync1_q <= sig_async;
            sync2_q <= sync1_q;
            dly_q   <= sync2_q;
        end
    end

    assign edge_pulse = sync2_q ^ dly_q;

endmodule

// File: rtl/sdi_clk_mode_detect.sv
// Measures the clock under test against a free-running reference toggle and
// classifies it as 74.25 / 148.5 / 297 MHz. A MODE code is reported once
// LOCK_CNT consecutive windows agree; a missing reference is flagged after
// TIMEOUT cycles without an edge.
`timescale 1ns/1ps
module sdi_clk_mode_detect
    import sdi_clk_pkg::*;
#(
    parameter int unsigned CNT_W    = 11,
    parameter int unsigned EXP_74   = 74,
    parameter int unsigned EXP_148  = 149,
    parameter int unsigned EXP_297  = 297,
    parameter int unsigned TOL      = 3,
    parameter int unsigned LOCK_CNT = 4,
    parameter int unsigned TIMEOUT  = 1023
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ref_tgl,
    output logic [2:0]       mode,
    output logic             mode_valid,
    output logic             meas_done,
    output logic [CNT_W-1:0] meas_cnt,
    output logic             ref_lost,
    output state_e           dbg_state
);

    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] TIMEOUT_V = CNT_W'(TIMEOUT);
    localparam int unsigned      MW        = (LOCK_CNT < 2) ? 1 : $clog2(LOCK_CNT + 1);
    localparam logic [MW-1:0]    MATCH_ONE = {{(MW-1){1'b0}}, 1'b1};
    localparam logic [MW-1:0]    LOCK_V    = MW'(LOCK_CNT);

    logic             edge_pulse;
    logic             timeout;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] meas_cnt_q, meas_cnt_d;
    logic             first_q, first_d;
    logic             done_q, done_d;
    logic             lost_q, lost_d;

    state_e           state_q, state_d;
    rate_e            cand_q, cand_d;
    rate_e            rate;
    logic [MW-1:0]    match_q, match_d;
    logic [MW-1:0]    match_inc;
    logic [2:0]       mode_q, mode_d;

    sdi_sync_edge u_sync_edge (
        .clk        (clk),
        .rst_n      (rst_n),
        .sig_async  (ref_tgl),
        .edge_pulse (edge_pulse)
    );

    // An edge in the same cycle as the timeout threshold takes priority.
    assign timeout = (cnt_q == TIMEOUT_V) && !edge_pulse;

    // True when v lies within TOL of expv; lower bound clamps at zero.
    function automatic logic in_win(input logic [CNT_W-1:0] v, input int unsigned expv);
        int unsigned val;
        int unsigned lo;
        int unsigned hi;
        val = 32'(v);
        lo  = (expv > TOL) ? (expv - TOL) : 0;
        hi  = expv + TOL;
        return (val >= lo) && (val <= hi);
    endfunction

    // Rate class of the most recently published window.
    always_comb begin
        rate = R_UNKNOWN;
        if (in_win(meas_cnt_q, EXP_74)) begin
            rate = R74;
        end else if (in_win(meas_cnt_q, EXP_148)) begin
            rate = R148;
        end else if (in_win(meas_cnt_q, EXP_297)) begin
            rate = R297;
        end
    end

    // Window counter, publication of completed windows and reference-loss tracking.
    always_comb begin
        cnt_d      = cnt_q;
        meas_cnt_d = meas_cnt_q;
        first_d    = first_q;
        done_d     = 1'b0;
        lost_d     = lost_q;
        if (edge_pulse) begin
            cnt_d  = '0;
            lost_d = 1'b0;
            if (first_q) begin
                // Window since reset or since the reference came back is partial.
                first_d = 1'b0;
            end else begin
                meas_cnt_d = (cnt_q == CNT_MAX) ? CNT_MAX : (cnt_q + CNT_ONE);
                done_d     = 1'b1;
            end
        end else if (timeout) begin
            // Counter parks at the threshold until the reference returns.
            lost_d  = 1'b1;
            first_d = 1'b1;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    // Measurement-side registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            meas_cnt_q <= '0;
            first_q    <= 1'b1;
            done_q     <= 1'b0;
            lost_q     <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            meas_cnt_q <= meas_cnt_d;
            first_q    <= first_d;
            done_q     <= done_d;
            lost_q     <= lost_d;
        end
    end

    assign match_inc = match_q + MATCH_ONE;

    // Lock FSM: advances only on published windows, drops to HUNT on timeout.
    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        match_d = match_q;
        mode_d  = mode_q;
        if (timeout) begin
            state_d = HUNT;
            match_d = '0;
        end else if (done_q) begin
            case (state_q)
                HUNT: begin
                    if (rate != R_UNKNOWN) begin
                        cand_d = rate;
                        if (LOCK_CNT <= 1) begin
                            state_d = LOCKED;
                            mode_d  = rate_to_mode(rate);
                        end else begin
                            match_d = MATCH_ONE;
                            state_d = CHECK;
                        end
                    end
                end
                CHECK: begin
                    if (rate == R_UNKNOWN) begin
                        state_d = HUNT;
                        match_d = '0;
                    end else if (rate == cand_q) begin
                        if (match_inc == LOCK_V) begin
                            state_d = LOCKED;
                            mode_d  = rate_to_mode(cand_q);
                        end else begin
                            match_d = match_inc;
                        end
                    end else begin
                        cand_d  = rate;
                        match_d = MATCH_ONE;
                    end
                end
                LOCKED: begin
                    // mode keeps its last value; only the valid flag drops.
                    if (rate != cand_q) begin
                        state_d = HUNT;
                        match_d = '0;
                    end
                end
                default: begin
                    state_d = HUNT;
                    match_d = '0;
                end
            endcase
        end
    end

    // Lock FSM registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= HUNT;
            cand_q  <= R_UNKNOWN;
            match_q <= '0;
            mode_q  <= MODE_HD;
        end else begin
            state_q <= state_d;
            cand_q  <= cand_d;
            match_q <= match_d;
            mode_q  <= mode_d;
        end
    end

    assign mode       = mode_q;
    assign mode_valid = (state_q == LOCKED);
    assign meas_done  = done_q;
    assign meas_cnt   = meas_cnt_q;
    assign ref_lost   = lost_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_sdi_clk_mode_detect.sv
// Bench for sdi_clk_mode_detect. Reference edges are placed an exact number
// of clk cycles apart, so every published window length is known up front.
// Each window pushes {mode_valid, mode, meas_cnt} expected after it.
`timescale 1ns/1ps
module tb_sdi_clk_mode_detect;
    import sdi_clk_pkg::*;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        rst_n;
    logic        ref_tgl;
    real         half_ns = 3.367;

    logic [2:0]  mode;
    logic        mode_valid;
    logic        meas_done;
    logic [10:0] meas_cnt;
    logic        ref_lost;
    state_e      dbg_state;

    always #(half_ns) clk = ~clk;

    sdi_clk_mode_detect dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ref_tgl    (ref_tgl),
        .mode       (mode),
        .mode_valid (mode_valid),
        .meas_done  (meas_done),
        .meas_cnt   (meas_cnt),
        .ref_lost   (ref_lost),
        .dbg_state  (dbg_state)
    );

    // ---------------- checking ----------------
    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- scoreboard ----------------
    logic [14:0] exp_q[$];
    logic [14:0] ent;
    logic        pend      = 1'b0;
    logic        exp_v_now = 1'b0;
    logic [2:0]  exp_m_now = 3'b000;

    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend      = 1'b0;
            exp_v_now = 1'b0;
            exp_m_now = 3'b000;
        end else begin
            if (ref_lost) exp_v_now = 1'b0;
            if (pend) begin
                check_eq("valid_e2", {31'd0, mode_valid}, {31'd0, ent[14]});
                check_eq("mode_e2", {29'd0, mode}, {29'd0, ent[13:11]});
                pend = 1'b0;
            end
            if (meas_done) begin
                if (exp_q.size() == 0) begin
                    check_eq("unexpected_done", {31'd0, meas_done}, 32'd0);
                end else begin
                    ent = exp_q.pop_front();
                    check_eq("meas_cnt", {21'd0, meas_cnt}, {21'd0, ent[10:0]});
                    check_eq("valid_e1", {31'd0, mode_valid}, {31'd0, exp_v_now});
                    check_eq("mode_e1", {29'd0, mode}, {29'd0, exp_m_now});
                    exp_v_now = ent[14];
                    exp_m_now = ent[13:11];
                    pend      = 1'b1;
                end
            end
        end
    end

    // ---------------- drivers ----------------
    // Toggle that starts a discarded partial window.
    task automatic first_edge();
        @(negedge clk);
        ref_tgl = ~ref_tgl;
    endtask

    // Next toggle exactly n cycles after the previous one.
    task automatic send_window(input int n, input logic v, input logic [2:0] m);
        repeat (n) @(posedge clk);
        @(negedge clk);
        exp_q.push_back({v, m, 11'(n)});
        ref_tgl = ~ref_tgl;
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        int lost_at;
        rst_n   = 1'b0;
        ref_tgl = 1'b0;
        #20;
        check_eq("rst_mode", {29'd0, mode}, 32'd0);
        check_eq("rst_valid", {31'd0, mode_valid}, 32'd0);
        check_eq("rst_done", {31'd0, meas_done}, 32'd0);
        check_eq("rst_cnt", {21'd0, meas_cnt}, 32'd0);
        check_eq("rst_lost", {31'd0, ref_lost}, 32'd0);
        check_eq("rst_state", {30'd0, dbg_state}, {30'd0, HUNT});
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // 148.5 MHz: first edge discarded, lock after the 4th window
        first_edge();
        for (int i = 0; i < 4; i++)
            send_window($urandom_range(150, 148), i == 3, (i == 3) ? MODE_3G : MODE_HD);

        // 74.25 MHz: drop on first window, relock after 4 more
        half_ns = 6.734;
        for (int i = 0; i < 5; i++)
            send_window($urandom_range(75, 73), i == 4, (i == 4) ? MODE_HD : MODE_3G);

        // 297 MHz
        half_ns = 1.684;
        for (int i = 0; i < 5; i++)
            send_window($urandom_range(300, 294), i == 4, (i == 4) ? MODE_12G : MODE_HD);

        // reference stops: ref_lost expected 1027 cycles after the last toggle
        lost_at = 0;
        for (int i = 1; i <= 1100; i++) begin
            @(posedge clk);
            #0.2;
            if (ref_lost) begin
                lost_at = i;
                break;
            end
        end
        check_eq("lost_latency", lost_at, 32'd1027);
        check_eq("lost_valid", {31'd0, mode_valid}, 32'd0);
        check_eq("lost_mode", {29'd0, mode}, {29'd0, MODE_12G});
        check_eq("lost_state", {30'd0, dbg_state}, {30'd0, HUNT});

        // reference returns: clears at E+1, that edge is not published
        first_edge();
        fork
            begin
                repeat (2) @(posedge clk);
                #0.2;
                check_eq("lost_hold_e", {31'd0, ref_lost}, 32'd1);
                @(posedge clk);
                #0.2;
                check_eq("lost_clear_e1", {31'd0, ref_lost}, 32'd0);
            end
            send_window($urandom_range(300, 294), 1'b0, MODE_12G);
        join
        for (int i = 0; i < 3; i++)
            send_window($urandom_range(300, 294), i == 2, MODE_12G);

        // 134 MHz: unknown class, never locks
        half_ns = 3.731;
        for (int i = 0; i < 6; i++)
            send_window($urandom_range(136, 132), 1'b0, MODE_12G);
        // alternating 74 / 149 windows, ending on 74
        for (int i = 0; i < 7; i++)
            send_window((i % 2 == 0) ? 74 : 149, 1'b0, MODE_12G);

        // back to 148.5 MHz and lock before the reset pulse
        half_ns = 3.367;
        for (int i = 0; i < 4; i++)
            send_window(149, i == 3, (i == 3) ? MODE_3G : MODE_12G);
        repeat (6) @(negedge clk);

        // short asynchronous reset between clock edges
        @(posedge clk);
        #1;
        rst_n   = 1'b0;
        ref_tgl = 1'b0;
        #1;
        check_eq("arst_mode", {29'd0, mode}, 32'd0);
        check_eq("arst_valid", {31'd0, mode_valid}, 32'd0);
        check_eq("arst_cnt", {21'd0, meas_cnt}, 32'd0);
        check_eq("arst_done", {31'd0, meas_done}, 32'd0);
        check_eq("arst_lost", {31'd0, ref_lost}, 32'd0);
        #2;
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        first_edge();
        for (int i = 0; i < 4; i++)
            send_window($urandom_range(150, 148), i == 3, (i == 3) ? MODE_3G : MODE_HD);
        repeat (6) @(negedge clk);

        check_eq("queue_drained", exp_q.size(), 32'd0);
        check_eq("final_valid", {31'd0, mode_valid}, 32'd1);
        check_eq("final_mode", {29'd0, mode}, {29'd0, MODE_3G});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
